// File: rtl/age_matrix_sel.sv
// age_matrix_sel: entry-valid tracking, age matrix and a GNT_NUM-wide
// oldest-first selector for a DEPTH-entry issue queue or request buffer.
// older_q[i][j] = 1 means entry j is older than entry i.
// Granted entries are freed when gnt_ready is high.
// Optional occupancy outputs (occ, full) are enabled by defining
// AGE_MATRIX_SEL_OCC_EN.
module age_matrix_sel #(
   parameter int DEPTH   = 8,
   parameter int GNT_NUM = 2,
   parameter int IDX_W   = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alloc_en,
   input  logic [DEPTH-1:0]         v_alloc,
   input  logic [DEPTH-1:0]         v_req,
   input  logic                     gnt_ready,
   output logic [DEPTH-1:0]         v_entry,
   output logic [GNT_NUM-1:0]       gnt_vld,
   output logic [GNT_NUM*IDX_W-1:0] gnt_idx,
   output logic [DEPTH-1:0]         v_grant
`ifdef AGE_MATRIX_SEL_OCC_EN
   ,
   output logic [IDX_W:0]           occ,
   output logic                     full
`endif
);

   // Handshake: a grant in slot k is offered while gnt_vld[k] is high; it is
   // taken (and its entry freed) on a clock edge where gnt_ready is high.
   // With gnt_ready low the grants are simply recomputed next cycle.

   logic [DEPTH-1:0] v_entry_q, v_entry_d;
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] older_d [DEPTH];
   logic [DEPTH-1:0] req;
   logic [DEPTH-1:0] dealloc;
   logic [DEPTH-1:0] alloc;
   logic [DEPTH-1:0] keep;
   logic [IDX_W:0]   req_cnt;
   logic [IDX_W:0]   rank [DEPTH];

   function automatic logic [IDX_W:0] popcnt(input logic [DEPTH-1:0] v);
      logic [IDX_W:0] cnt;
      cnt = '0;
      for (int b = 0; b < DEPTH; b++) begin
         cnt = cnt + {{IDX_W{1'b0}}, v[b]};
      end
      return cnt;
   endfunction

   assign v_entry = v_entry_q;

   // Oldest-first selection: an entry's slot is the number of older requesters.
   always_comb begin
      req     = v_req & v_entry_q;
      req_cnt = popcnt(req);
      v_grant = '0;
      gnt_vld = '0;
      gnt_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rank[i] = popcnt(req & older_q[i]);
      end
      for (int k = 0; k < GNT_NUM; k++) begin
         gnt_vld[k] = (req_cnt > (IDX_W+1)'(k));
         for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && (rank[i] == (IDX_W+1)'(k))) begin
               gnt_idx[k*IDX_W +: IDX_W] = IDX_W'(i);
               v_grant[i]                = 1'b1;
            end
         end
      end
   end

   // Next valid vector and age matrix; allocation wins over a same-cycle free.
   always_comb begin
      dealloc   = v_grant & {DEPTH{gnt_ready}};
      alloc     = v_alloc & {DEPTH{alloc_en}};
      keep      = v_entry_q & ~dealloc;
      v_entry_d = keep | alloc;
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc[i]) begin
            // Everything surviving is older, plus lower-index same-cycle allocations.
            older_d[i] = (keep | (alloc & ((DEPTH'(1) << i) - DEPTH'(1))))
                         & ~(DEPTH'(1) << i);
         end else begin
            // Newly allocated entries are younger than every existing one.
            older_d[i] = older_q[i] & ~alloc;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_entry_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            older_q[i] <= '0;
         end
      end else begin
         v_entry_q <= v_entry_d;
         for (int i = 0; i < DEPTH; i++) begin
            older_q[i] <= older_d[i];
         end
      end
   end

`ifdef AGE_MATRIX_SEL_OCC_EN
   logic [IDX_W:0] occ_q, occ_d;

   assign occ_d = popcnt(v_entry_d);
   assign occ   = occ_q;
   assign full  = (occ_q == (IDX_W+1)'(DEPTH));

   // Occupancy tracks v_entry in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end
`endif

`ifndef SYNTHESIS
   // Re-allocating a live entry that is not being freed would corrupt its age.
   a_no_live_alloc: assert property (@(posedge clk) disable iff (!rst_n)
      !(alloc_en && |(v_alloc & v_entry_q & ~dealloc)));
`endif

endmodule

// File: doc/age_matrix_sel.md
Name: age_matrix_sel

Overview:
- Parametrised successor to the single-grant age-matrix/oldest-first arbiter pair.
- Merges entry-valid tracking, age-matrix update and a GNT_NUM-wide oldest-first selector into one block.
- Sits beside an issue queue or request buffer of DEPTH entries. Each cycle it grants up to GNT_NUM requesting entries, oldest first.
- Accepted grants free their entries.

Parameters:
- DEPTH, 8, number of tracked entries (>=2).
- GNT_NUM, 2, maximum grants per cycle (1..DEPTH).
- IDX_W, $clog2(DEPTH), entry index width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alloc_en  input  1  allocation strobe.
- v_alloc  input  DEPTH  entries allocated this cycle; multiple bits allowed.
- v_req  input  DEPTH  per-entry request (ready to be selected).
- gnt_ready  input  1  downstream accepts all current grants this cycle.
- v_entry  output  DEPTH  registered entry-valid vector.
- gnt_vld  output  GNT_NUM  slot k holds a grant.
- gnt_idx  output  GNT_NUM*IDX_W  slot k index in bits [k*IDX_W +: IDX_W]; slot 0 is oldest.
- v_grant  output  DEPTH  OR of all granted entries (one-hot union).

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state:
  - age matrix all 0; v_entry = 0.
  - Outputs therefore read gnt_vld = 0, gnt_idx = 0, v_grant = 0.
  - Reset mid-operation drops all entries immediately; no grant survives.
- Age matrix definition: older[i][j] = 1 means entry j is older than entry i. Diagonal is always 0.
- Allocation of entry i (alloc_en & v_alloc[i]), applied at the clock edge:
  - Row i <= (v_entry & ~dealloc) | (v_alloc & alloc_en & lower-index mask of i).
  - Among same-cycle allocations, the lower index is older.
  - Column i in every other row <= 0 (entry i is the youngest).
- Deallocation: dealloc = v_grant & {DEPTH{gnt_ready}}. v_entry[i] <= 0 for every dealloc bit. Matrix rows of freed entries are don't-care; they are rewritten on the next allocation.
- Same entry allocated and deallocated in the same cycle: allocation wins. The entry stays valid and becomes youngest.
- Allocating an already-valid entry that is not being deallocated is illegal. Covered by a simulation assertion (not synthesised).
- alloc_en = 0: v_alloc is ignored.
- Selection (combinational from registered state plus v_req, zero-cycle latency):
  - req = v_req & v_entry.
  - rank[i] = popcount(req & older[i]).
  - Entry i is granted in slot k iff req[i] and rank[i] == k, for k < GNT_NUM.
  - Ranks are unique, so each slot holds at most one entry.
- Slot filling:
  - gnt_vld[k] = 1 iff popcount(req) > k.
  - gnt_idx of an empty slot = 0.
- gnt_ready = 0: grants stay asserted and are recomputed each cycle. No entry is freed and no state changes except allocation.
- No fairness beyond age: the oldest requester always wins slot 0. Starvation of younger entries is allowed by design.
- Full/empty:
  - v_entry all-ones is legal (full); the allocator must not allocate.
  - v_entry = 0 gives no grants regardless of v_req.

Optional Feature:
- Macro: AGE_MATRIX_SEL_OCC_EN.
- Defined: adds outputs occ (IDX_W+1 bits, registered popcount of v_entry, reset 0) and full (occ == DEPTH). occ updates in the same cycle as v_entry, including simultaneous alloc/dealloc.
- Undefined: the ports and logic are absent; the interface is exactly as listed above.

Test Plan (all with DEPTH=4, GNT_NUM=2):
- Reset with v_req=4'hF:
  - gnt_vld=0, v_grant=0, v_entry=0 while rst_n low.
  - Asserting rst_n mid-run with v_entry=4'hF clears v_entry asynchronously.
- Allocate 2, then 0, then 3, one per cycle; v_req=4'hF; gnt_ready=0:
  - gnt_idx slot0=2, slot1=0, gnt_vld=2'b11, v_grant=4'b0101.
  - State is held across 3 cycles.
- Same state, gnt_ready=1 for one cycle:
  - Next cycle v_entry=4'b1000, gnt_vld=2'b01, slot0=3.
- Same-cycle allocation v_alloc=4'b1010 from empty:
  - Entry 1 is older than entry 3, so slot0=1, slot1=3.
- Entry 0 granted with gnt_ready=1 and re-allocated in the same cycle, with entry 1 valid:
  - Entry 0 stays valid and becomes youngest.
  - Next grant order is slot0=1, slot1=0.
- AGE_MATRIX_SEL_OCC_EN defined:
  - Fill 4 entries, then occ=4 and full=1.
  - Free 2 entries while allocating 1 in the same cycle, then occ=3 and full=0.
